// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Byte-lane selects, little-endian: lane 0 is bits 7:0
   localparam logic [1:0] LANE0 = 2'd0;
   localparam logic [1:0] LANE1 = 2'd1;
   localparam logic [1:0] LANE2 = 2'd2;
   localparam logic [1:0] LANE3 = 2'd3;

   // Per-byte write enable for a store: one lane for sb, all lanes for sw
   function automatic logic [3:0] byte_wen(input logic savebyte, input logic [1:0] addr);
      logic [3:0] wen;
      wen = 4'hF;
      if (savebyte) begin
         case (addr)
            LANE0:   wen = 4'b0001;
            LANE1:   wen = 4'b0010;
            LANE2:   wen = 4'b0100;
            LANE3:   wen = 4'b1000;
            default: wen = 4'b0000;
         endcase
      end
      return wen;
   endfunction

   // Copy a store byte onto every lane so the enabled lane picks it up
   function automatic logic [31:0] rep_byte(input logic [7:0] b);
      return {4{b}};
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data RAM: synchronous byte-enabled write, combinational read.
module dmem_array #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Byte-lane writes on the rising edge
   // NOTE: the RAM has no reset; contents must survive a core reset and a
   // reset loop over the whole array would prevent mapping onto a RAM macro.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: single-cycle stores, multi-cycle loads
// with a stall handshake, and a sticky error flag for protocol/alignment faults.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter int READ_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic        savebyte,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        stall,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(READ_LAT + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(READ_LAT - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [AW-1:0] idx, idx_q, raddr;
   logic [31:0]   rdata_arr;
   logic [3:0]    wen;
   logic [31:0]   wdata;
   logic          misalign;

   // Control strobes produced by the output process
   logic          mem_we;
   logic          rd_load;
   logic          cnt_load;
   logic          idx_load;
   logic          err_set;

   // Upper address bits are ignored: addresses wrap modulo 4*DEPTH
   logic          unused_addr;
   assign unused_addr = ^dataadr[31:AW+2];

   assign idx      = dataadr[AW+1:2];
   assign misalign = |dataadr[1:0];

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned and infers a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (memread && !memwrite) state_nx = (READ_LAT == 1) ? DONE : WAIT;
         end
         WAIT: begin
            if (cnt == CNT_LAST) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs and datapath strobes; everything is quiet while reset is high
   always_comb begin
      stall    = 1'b0;
      mem_we   = 1'b0;
      rd_load  = 1'b0;
      cnt_load = 1'b0;
      idx_load = 1'b0;
      err_set  = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (memwrite) begin
                  // A store always wins; a simultaneous read is dropped as a fault
                  mem_we  = 1'b1;
                  err_set = memread | (!savebyte & misalign);
               end else if (memread) begin
                  stall    = 1'b1;
                  idx_load = 1'b1;
                  err_set  = misalign;
                  if (READ_LAT == 1) rd_load  = 1'b1;
                  else               cnt_load = 1'b1;
               end
            end
            WAIT: begin
               stall = 1'b1;
               if (cnt == CNT_LAST) rd_load = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Read address: live index when the request arrives, latched index afterwards
   assign raddr = (state == IDLE) ? idx : idx_q;
   assign wen   = mem_we ? byte_wen(savebyte, dataadr[1:0]) : 4'h0;
   assign wdata = savebyte ? rep_byte(writedata[7:0]) : writedata;

   // Load result, latency counter and sticky error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= 32'h0;
         cnt      <= '0;
         err      <= 1'b0;
      end else begin
         if (cnt_load)           cnt <= CNT_INIT;
         else if (state == WAIT) cnt <= cnt - CNT_LAST;
         if (rd_load)  readdata <= rdata_arr;
         if (err_set)  err      <= 1'b1;
      end
   end

   // Word index captured at request time; only meaningful during a load
   always_ff @(posedge clk) begin
      if (idx_load) idx_q <= idx;
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (wen),
      .waddr (idx),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata_arr)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at READ_LAT=2 and READ_LAT=3.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset, memread, memwrite, savebyte, sel;
   logic [31:0] dataadr, writedata;

   logic        mr2, mw2, mr3, mw3;
   logic [31:0] rd2, rd3;
   logic        st2, st3, er2, er3;
   logic [31:0] rd_s;
   logic        st_s, er_s;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat;
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   // sel picks which instance sees the requests and is observed
   assign mr2  = memread  & ~sel;
   assign mw2  = memwrite & ~sel;
   assign mr3  = memread  &  sel;
   assign mw3  = memwrite &  sel;
   assign rd_s = sel ? rd3 : rd2;
   assign st_s = sel ? st3 : st2;
   assign er_s = sel ? er3 : er2;

   dmem_responder #(.DEPTH(64), .READ_LAT(2)) u_dut2 (
      .clk(clk), .reset(reset), .memread(mr2), .memwrite(mw2), .savebyte(savebyte),
      .dataadr(dataadr), .writedata(writedata), .readdata(rd2), .stall(st2), .err(er2)
   );

   dmem_responder #(.DEPTH(64), .READ_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .memread(mr3), .memwrite(mw3), .savebyte(savebyte),
      .dataadr(dataadr), .writedata(writedata), .readdata(rd3), .stall(st3), .err(er3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset    = 1'b1;
      memread  = 1'b0;
      memwrite = 1'b0;
      @(negedge clk);
      check("rst_stall", {31'b0, st_s}, 32'h0);
      step();
      reset   = 1'b0;
      last_rd = 32'h0;
      @(negedge clk);
      check("rst_rd",     rd_s, 32'h0);
      check("rst_err",    {31'b0, er_s}, 32'h0);
      check("rst_stall2", {31'b0, st_s}, 32'h0);
      step();
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic sb);
      dataadr   = addr;
      writedata = data;
      savebyte  = sb;
      memwrite  = 1'b1;
      @(negedge clk);
      check("st_stall", {31'b0, st_s}, 32'h0);
      step();
      memwrite = 1'b0;
      savebyte = 1'b0;
   endtask

   // Request held through stall and the DONE cycle, as the pipeline would
   task automatic load(input logic [31:0] addr, input logic [31:0] exp);
      dataadr = addr;
      memread = 1'b1;
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         check("ld_stall", {31'b0, st_s}, 32'h1);
         check("ld_hold",  rd_s, last_rd);
         step();
      end
      @(negedge clk);
      check("ld_done_stall", {31'b0, st_s}, 32'h0);
      check("ld_data",       rd_s, exp);
      step();
      memread = 1'b0;
      last_rd = exp;
   endtask

   task automatic check_err(input string tag, input logic exp);
      @(negedge clk);
      check(tag, {31'b0, er_s}, {31'b0, exp});
      step();
   endtask

   initial begin
      reset = 1'b1; memread = 1'b0; memwrite = 1'b0; savebyte = 1'b0;
      dataadr = 32'h0; writedata = 32'h0; sel = 1'b0; lat = 2; last_rd = 32'h0;

      // READ_LAT=2: store, load, address aliasing
      do_reset();
      store(32'd12, 32'h0000003F, 1'b0);
      check_err("sw_ok_err", 1'b0);
      load(32'd12,  32'h0000003F);
      load(32'd268, 32'h0000003F);

      // Byte stores into lanes 1 and 3
      store(32'd12, 32'h11223344, 1'b0);
      store(32'd13, 32'h000000AB, 1'b1);
      load(32'd12, 32'h1122AB44);
      store(32'd15, 32'h000000CD, 1'b1);
      load(32'd12, 32'hCD22AB44);
      check_err("sb_ok_err", 1'b0);

      // Misaligned word store: aligned word written, sticky err
      store(32'd14, 32'h00000055, 1'b0);
      check_err("mis_err", 1'b1);
      load(32'd12, 32'h00000055);
      check_err("mis_sticky", 1'b1);
      do_reset();

      // Memory survives reset; then read+write collision
      load(32'd12, 32'h00000055);
      dataadr = 32'd8; writedata = 32'h00000077; memread = 1'b1; memwrite = 1'b1;
      @(negedge clk);
      check("rw_stall", {31'b0, st_s}, 32'h0);
      step();
      memread = 1'b0; memwrite = 1'b0;
      @(negedge clk);
      check("rw_err",   {31'b0, er_s}, 32'h1);
      check("rw_rd",    rd_s, last_rd);
      check("rw_stall2", {31'b0, st_s}, 32'h0);
      step();
      load(32'd8, 32'h00000077);

      // READ_LAT=3: back-to-back loads
      sel = 1'b1; lat = 3;
      do_reset();
      store(32'd0, 32'h0000000A, 1'b0);
      store(32'd4, 32'h0000000B, 1'b0);
      load(32'd0, 32'h0000000A);
      load(32'd4, 32'h0000000B);

      // Reset during WAIT aborts the load
      dataadr = 32'd4; memread = 1'b1;
      @(negedge clk);
      check("ab_req_stall", {31'b0, st_s}, 32'h1);
      step();
      reset = 1'b1;
      @(negedge clk);
      check("ab_rst_stall", {31'b0, st_s}, 32'h0);
      step();
      reset = 1'b0; memread = 1'b0; last_rd = 32'h0;
      @(negedge clk);
      check("ab_stall", {31'b0, st_s}, 32'h0);
      check("ab_rd",    rd_s, 32'h0);
      check("ab_err",   {31'b0, er_s}, 32'h0);
      step();
      load(32'd4, 32'h0000000B);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
